iob_pbus_split_n: RTL and testbench



---
 rtl/iob_pbus_pkg.sv | 12 +
 rtl/iob_pbus_split_tracker.sv | 76 +++++++
 rtl/iob_pbus_split_n.sv | 105 ++++++++++
 tb/tb_iob_pbus_split_n.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_pbus_pkg.sv
// Shared constants and helpers for the IOb peripheral-bus splitter family.
package iob_pbus_pkg;

    localparam int          MAX_RD_LIMIT     = 15;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Select field width; a 2-way split still needs one bit.
    function automatic int sel_width(input int n_mgr);
        return (n_mgr > 2) ? $clog2(n_mgr) : 1;
    endfunction

endpackage

// File: rtl/iob_pbus_split_tracker.sv
// Outstanding-read bookkeeping for iob_pbus_split_n: pending count/target,
// decode-error response timing and the read stall decision.
module iob_pbus_split_tracker
    import iob_pbus_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int MAX_RD = 4
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             rst_i,
    input  logic             req_rd,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_in_range,
    input  logic             req_accept,
    input  logic             rsp_fire,
    output logic             stall_o,
    output logic             pend_any_o,
    output logic [SEL_W-1:0] pend_sel_o,
    output logic             pend_err_o,
    output logic             err_rv_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(MAX_RD + 1);

    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W-1:0] pend_cnt_nxt;
    logic             rd_accept;

    assign rd_accept  = req_accept & req_rd;
    assign pend_any_o = (pend_cnt != '0);

    // All outstanding reads must share one target so responses stay in order.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        stall_o = 1'b0;
        if (req_rd && pend_any_o) begin
            stall_o = (pend_cnt == CNT_W'(MAX_RD))
                    || (req_sel != pend_sel_o)
                    || (req_in_range == pend_err_o)
                    || !req_in_range;
        end
    end

    always_comb begin
        pend_cnt_nxt = pend_cnt;
        unique case ({rd_accept, rsp_fire})
            2'b10:   pend_cnt_nxt = pend_cnt + 1'b1;
            2'b01:   pend_cnt_nxt = pend_cnt - 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                pend_cnt   <= '0;
                pend_sel_o <= '0;
                pend_err_o <= 1'b0;
                err_rv_o   <= 1'b0;
                err_o      <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt_nxt;
                if (rd_accept) begin
                    pend_sel_o <= req_sel;
                    pend_err_o <= ~req_in_range;
                end
                err_rv_o <= rd_accept & ~req_in_range;
                err_o    <= req_accept & ~req_in_range;
            end
        end
    end

endmodule

// File: rtl/iob_pbus_split_n.sv
// N-way IOb peripheral-bus splitter: decodes the top address bits to a manager
// port, pipelines reads to a single target and answers unmapped codes itself.
module iob_pbus_split_n
    import iob_pbus_pkg::*;
#(
    parameter int                N_MGR    = 4,
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter int                MAX_RD   = 4,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT),
    localparam int               SEL_W    = sel_width(N_MGR),
    localparam int               M_ADDR_W = ADDR_W - SEL_W,
    localparam int               STRB_W   = DATA_W / 8
) (
    input  logic                         clk_i,
    input  logic                         cke_i,
    input  logic                         rst_i,
    input  logic                         s_iob_valid_i,
    input  logic [ADDR_W-1:0]            s_iob_addr_i,
    input  logic [DATA_W-1:0]            s_iob_wdata_i,
    input  logic [STRB_W-1:0]            s_iob_wstrb_i,
    output logic                         s_iob_ready_o,
    output logic                         s_iob_rvalid_o,
    output logic [DATA_W-1:0]            s_iob_rdata_o,
    output logic [N_MGR-1:0]             m_iob_valid_o,
    output logic [N_MGR*M_ADDR_W-1:0]    m_iob_addr_o,
    output logic [N_MGR*DATA_W-1:0]      m_iob_wdata_o,
    output logic [N_MGR*STRB_W-1:0]      m_iob_wstrb_o,
    input  logic [N_MGR-1:0]             m_iob_ready_i,
    input  logic [N_MGR-1:0]             m_iob_rvalid_i,
    input  logic [N_MGR*DATA_W-1:0]      m_iob_rdata_i,
    output logic                         err_o
);

    if (N_MGR < 2 || N_MGR > 16 || MAX_RD < 1 || MAX_RD > MAX_RD_LIMIT) begin : g_bad_param
        $error("iob_pbus_split_n: N_MGR or MAX_RD out of range");
    end

    logic [SEL_W-1:0]  sel;
    logic              in_range;
    logic              rd;
    logic              stall;
    logic              accept;
    logic [N_MGR-1:0]  hit;
    logic [N_MGR-1:0]  pend_hit;
    logic              mgr_ready;
    logic              mgr_rvalid;
    logic [DATA_W-1:0] mgr_rdata;
    logic              pend_any;
    logic [SEL_W-1:0]  pend_sel;
    logic              pend_err;
    logic              err_rv;

    assign sel = s_iob_addr_i[ADDR_W-1 -: SEL_W];
    assign rd  = (s_iob_wstrb_i == '0);

    for (genvar g = 0; g < N_MGR; g++) begin : g_mgr
        assign hit[g]      = (sel == SEL_W'(g));
        assign pend_hit[g] = (pend_sel == SEL_W'(g));

        assign m_iob_valid_o[g]                        = s_iob_valid_i & hit[g] & ~stall & ~rst_i;
        assign m_iob_addr_o[g*M_ADDR_W +: M_ADDR_W]    = s_iob_addr_i[M_ADDR_W-1:0];
        assign m_iob_wdata_o[g*DATA_W +: DATA_W]       = s_iob_wdata_i;
        assign m_iob_wstrb_o[g*STRB_W +: STRB_W]       = hit[g] ? s_iob_wstrb_i : '0;
    end

    // Unmapped select codes match no hit bit, which is exactly the error class.
    assign in_range   = |hit;
    assign mgr_ready  = |(hit & m_iob_ready_i);
    assign mgr_rvalid = |(pend_hit & m_iob_rvalid_i);

    always_comb begin
        mgr_rdata = '0;
        for (int i = 0; i < N_MGR; i++) begin
            mgr_rdata |= m_iob_rdata_i[i*DATA_W +: DATA_W] & {DATA_W{pend_hit[i]}};
        end
    end

    // Decode-error requests are absorbed here, so they are always ready unless stalled.
    assign s_iob_ready_o  = ~rst_i & ~stall & (~in_range | mgr_ready);
    assign accept         = s_iob_valid_i & s_iob_ready_o;
    assign s_iob_rvalid_o = ~rst_i & pend_any & (pend_err ? err_rv : mgr_rvalid);
    assign s_iob_rdata_o  = pend_err ? ERR_DATA : mgr_rdata;

    iob_pbus_split_tracker #(
        .SEL_W  (SEL_W),
        .MAX_RD (MAX_RD)
    ) u_tracker (
        .clk_i        (clk_i),
        .cke_i        (cke_i),
        .rst_i        (rst_i),
        .req_rd       (rd),
        .req_sel      (sel),
        .req_in_range (in_range),
        .req_accept   (accept),
        .rsp_fire     (s_iob_rvalid_o),
        .stall_o      (stall),
        .pend_any_o   (pend_any),
        .pend_sel_o   (pend_sel),
        .pend_err_o   (pend_err),
        .err_rv_o     (err_rv),
        .err_o        (err_o)
    );

endmodule

// File: tb/tb_iob_pbus_split_n.sv
// Self-checking bench for iob_pbus_split_n (3 managers, so select code 3 is unmapped):
// directed scenarios followed by randomized traffic against a queue-based reference model.
module tb_iob_pbus_split_n;

    localparam int          N      = 3;
    localparam int          AW     = 8;
    localparam int          DW     = 32;
    localparam int          SW     = 2;
    localparam int          MAW    = AW - SW;
    localparam int          SBW    = DW / 8;
    localparam int          MAX_RD = 4;
    localparam logic [31:0] ERR    = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              cke, rst;
    logic              s_valid, s_ready, s_rvalid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [SBW-1:0]    s_wstrb;
    logic [N-1:0]      m_valid, m_ready, m_rvalid;
    logic [N*MAW-1:0]  m_addr;
    logic [N*DW-1:0]   m_wdata, m_rdata;
    logic [N*SBW-1:0]  m_wstrb;
    logic              err;

    always #5 clk = ~clk;

    iob_pbus_split_n #(
        .N_MGR    (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_RD   (MAX_RD),
        .ERR_DATA (ERR)
    ) dut (
        .clk_i          (clk),
        .cke_i          (cke),
        .rst_i          (rst),
        .s_iob_valid_i  (s_valid),
        .s_iob_addr_i   (s_addr),
        .s_iob_wdata_i  (s_wdata),
        .s_iob_wstrb_i  (s_wstrb),
        .s_iob_ready_o  (s_ready),
        .s_iob_rvalid_o (s_rvalid),
        .s_iob_rdata_o  (s_rdata),
        .m_iob_valid_o  (m_valid),
        .m_iob_addr_o   (m_addr),
        .m_iob_wdata_o  (m_wdata),
        .m_iob_wstrb_o  (m_wstrb),
        .m_iob_ready_i  (m_ready),
        .m_iob_rvalid_i (m_rvalid),
        .m_iob_rdata_i  (m_rdata),
        .err_o          (err)
    );

    int n_pass, n_total;

    // Stimulus for the next cycle
    logic             st_rst, st_cke, st_valid;
    logic [AW-1:0]    st_addr;
    logic [DW-1:0]    st_wdata;
    logic [SBW-1:0]   st_wstrb;
    logic [N-1:0]     st_ready, st_rvalid;
    logic [N*DW-1:0]  st_rdata;

    // Reference model: outstanding read targets in order (-1 = decode error)
    int pend_q[$];
    bit err_due, err_next;
    int mgr_out[N];

    // DUT outputs sampled in the most recent cycle
    logic             obs_ready, obs_rvalid, obs_err;
    logic [N-1:0]     obs_mvalid;
    logic [DW-1:0]    obs_rdata;
    logic [N*MAW-1:0] obs_maddr;
    logic [N*SBW-1:0] obs_wstrb;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_cycle(input bit do_check);
        int            tgt;
        bit            rd, busy, stall, acc;
        logic          e_ready, e_rvalid;
        logic [N-1:0]  e_mvalid;
        logic [DW-1:0] e_rdata;
        logic [N*SBW-1:0] e_wstrb;
        @(negedge clk);
        rst = st_rst; cke = st_cke; s_valid = st_valid; s_addr = st_addr;
        s_wdata = st_wdata; s_wstrb = st_wstrb;
        m_ready = st_ready; m_rvalid = st_rvalid; m_rdata = st_rdata;
        #1;
        tgt   = (int'(st_addr[AW-1 -: SW]) < N) ? int'(st_addr[AW-1 -: SW]) : -1;
        rd    = (st_wstrb == '0);
        busy  = (pend_q.size() != 0);
        stall = rd && busy && (pend_q.size() == MAX_RD || tgt != pend_q[0] || tgt < 0);
        e_ready  = !st_rst && !stall && (tgt < 0 || st_ready[tgt]);
        e_mvalid = '0;
        if (st_valid && tgt >= 0 && !stall && !st_rst) e_mvalid[tgt] = 1'b1;
        e_rvalid = 1'b0;
        e_rdata  = '0;
        if (busy && !st_rst) e_rvalid = (pend_q[0] < 0) ? err_due : st_rvalid[pend_q[0]];
        if (busy) e_rdata = (pend_q[0] < 0) ? ERR : st_rdata[pend_q[0]*DW +: DW];
        e_wstrb = '0;
        if (tgt >= 0) e_wstrb[tgt*SBW +: SBW] = st_wstrb;
        acc = st_valid && e_ready;

        obs_ready = s_ready; obs_rvalid = s_rvalid; obs_err = err; obs_mvalid = m_valid;
        obs_rdata = s_rdata; obs_maddr = m_addr; obs_wstrb = m_wstrb;
        if (do_check) begin
            check("ready", s_ready, e_ready);
            check("m_valid", m_valid, e_mvalid);
            check("rvalid", s_rvalid, e_rvalid);
            check("err", err, err_next);
            check("m_wstrb", m_wstrb, e_wstrb);
            check("m_addr", m_addr, {N{st_addr[MAW-1:0]}});
            check("m_wdata", m_wdata, {N{st_wdata}});
            if (e_rvalid) check("rdata", s_rdata, e_rdata);
        end

        @(posedge clk);
        if (st_cke) begin
            if (st_rst) begin
                pend_q.delete();
                err_due = 0; err_next = 0;
                foreach (mgr_out[i]) mgr_out[i] = 0;
            end else begin
                for (int i = 0; i < N; i++)
                    if (st_rvalid[i] && mgr_out[i] > 0) mgr_out[i]--;
                if (e_rvalid) void'(pend_q.pop_front());
                if (acc && rd) begin
                    pend_q.push_back(tgt);
                    if (tgt >= 0) mgr_out[tgt]++;
                end
                err_due  = acc && rd && tgt < 0;
                err_next = acc && tgt < 0;
            end
        end
    endtask

    task automatic req(input logic valid, input logic [AW-1:0] addr, input logic [SBW-1:0] wstrb,
                       input logic [N-1:0] ready, input logic [N-1:0] rvalid, input logic [DW-1:0] rdata);
        st_rst = 0; st_cke = 1; st_valid = valid; st_addr = addr; st_wdata = 32'h1234;
        st_wstrb = wstrb; st_ready = ready; st_rvalid = rvalid; st_rdata = {N{rdata}};
        run_cycle(1);
    endtask

    initial begin
        logic [SW-1:0] last_sel;
        n_pass = 0; n_total = 0;
        err_due = 0; err_next = 0;
        foreach (mgr_out[i]) mgr_out[i] = 0;

        // Reset with a live request on the bus: nothing may be forwarded
        st_rst = 1; st_cke = 1; st_valid = 1; st_addr = 8'h85; st_wdata = 32'h1234;
        st_wstrb = 4'hF; st_ready = '1; st_rvalid = '1; st_rdata = {N{32'h55}};
        run_cycle(0);
        run_cycle(1);
        check("rst_ready", obs_ready, 1'b0);
        check("rst_mvalid", obs_mvalid, 3'b000);

        // Write to manager 2
        req(1, 8'h85, 4'hF, 3'b100, 3'b000, 32'h0);
        check("t1_mvalid", obs_mvalid, 3'b100);
        check("t1_addr", obs_maddr[2*MAW +: MAW], 6'h05);
        check("t1_wstrb", obs_wstrb, 12'hF00);
        check("t1_ready", obs_ready, 1'b1);

        // Three pipelined reads to manager 1, answered two cycles after accept
        req(1, 8'h41, 4'h0, 3'b111, 3'b000, 32'h0);
        check("t2_acc0", obs_ready, 1'b1);
        req(1, 8'h42, 4'h0, 3'b111, 3'b000, 32'h0);
        check("t2_acc1", obs_ready, 1'b1);
        req(1, 8'h43, 4'h0, 3'b111, 3'b010, 32'hA1);
        check("t2_acc2", obs_ready, 1'b1);
        check("t2_rd1", obs_rdata, 32'hA1);
        req(0, 8'h00, 4'h0, 3'b111, 3'b010, 32'hA2);
        check("t2_rd2", obs_rdata, 32'hA2);
        req(0, 8'h00, 4'h0, 3'b111, 3'b010, 32'hA3);
        check("t2_rd3", obs_rdata, 32'hA3);

        // Read to manager 2 waits for the pending manager-0 read to drain
        req(1, 8'h01, 4'h0, 3'b111, 3'b000, 32'h0);
        req(1, 8'h81, 4'h0, 3'b111, 3'b000, 32'h0);
        check("t3_stall", obs_ready, 1'b0);
        check("t3_mvalid", obs_mvalid, 3'b000);
        req(1, 8'h81, 4'h0, 3'b111, 3'b001, 32'hB0);
        check("t3_rsp", obs_rvalid, 1'b1);
        check("t3_still", obs_ready, 1'b0);
        req(1, 8'h81, 4'h0, 3'b111, 3'b000, 32'h0);
        check("t3_acc", obs_mvalid, 3'b100);
        req(0, 8'h00, 4'h0, 3'b111, 3'b100, 32'hB1);

        // MAX_RD outstanding, fifth read waits one cycle past the freeing rvalid
        for (int i = 0; i < MAX_RD; i++) req(1, 8'h40 + 8'(i), 4'h0, 3'b111, 3'b000, 32'h0);
        req(1, 8'h44, 4'h0, 3'b111, 3'b000, 32'h0);
        check("t4_full", obs_ready, 1'b0);
        req(1, 8'h44, 4'h0, 3'b111, 3'b010, 32'hC0);
        check("t4_free_rsp", obs_rvalid, 1'b1);
        check("t4_free_stall", obs_ready, 1'b0);
        req(1, 8'h44, 4'h0, 3'b111, 3'b000, 32'h0);
        check("t4_acc", obs_ready, 1'b1);
        for (int i = 0; i < MAX_RD; i++) req(0, 8'h00, 4'h0, 3'b111, 3'b010, 32'hC1 + 32'(i));

        // Decode errors: read then write to unmapped select code 3
        req(1, 8'hC0, 4'h0, 3'b000, 3'b000, 32'h0);
        check("t5_ready", obs_ready, 1'b1);
        check("t5_mvalid", obs_mvalid, 3'b000);
        req(0, 8'h00, 4'h0, 3'b000, 3'b000, 32'h0);
        check("t5_rvalid", obs_rvalid, 1'b1);
        check("t5_rdata", obs_rdata, ERR);
        check("t5_err", obs_err, 1'b1);
        req(1, 8'hC4, 4'hF, 3'b000, 3'b000, 32'h0);
        check("t5_wr_ready", obs_ready, 1'b1);
        check("t5_wr_mvalid", obs_mvalid, 3'b000);
        req(0, 8'h00, 4'h0, 3'b000, 3'b000, 32'h0);
        check("t5_wr_err", obs_err, 1'b1);
        check("t5_no_rvalid", obs_rvalid, 1'b0);

        // Reset with two reads pending; the stale response is ignored
        req(1, 8'h02, 4'h0, 3'b111, 3'b000, 32'h0);
        req(1, 8'h03, 4'h0, 3'b111, 3'b000, 32'h0);
        st_rst = 1; st_valid = 0; st_rvalid = '0;
        run_cycle(1);
        req(0, 8'h00, 4'h0, 3'b111, 3'b001, 32'hD0);
        check("t6_stale", obs_rvalid, 1'b0);
        req(1, 8'h81, 4'h0, 3'b111, 3'b000, 32'h0);
        check("t6_acc", obs_ready, 1'b1);
        req(0, 8'h00, 4'h0, 3'b111, 3'b100, 32'hD1);
        check("t6_rsp", obs_rvalid, 1'b1);

        // Randomized traffic, including stale/unrelated manager rvalids, cke gaps and resets
        last_sel = 2'd1;
        for (int c = 0; c < 3000; c++) begin
            st_rst   = ($urandom_range(0, 63) == 0);
            st_cke   = ($urandom_range(0, 9) != 0);
            st_valid = st_cke && ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 4) last_sel = 2'($urandom_range(0, 3));
            st_addr  = {last_sel, 6'($urandom)};
            st_wstrb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            st_wdata = $urandom;
            st_ready = 3'($urandom) | 3'($urandom);
            for (int i = 0; i < N; i++) begin
                st_rvalid[i] = st_cke && !st_rst &&
                               ($urandom_range(0, 9) < ((mgr_out[i] > 0) ? 5 : 2));
                st_rdata[i*DW +: DW] = $urandom;
            end
            run_cycle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
